// File: rtl/axi_ethernet_reset_sequencer.sv
// Clock-status monitor and per-channel pma_reset/glbl_rst release sequencer.
// Define RESET_SEQ_LOSS_CNT_EN to build the per-channel saturating lock-loss counters.
module axi_ethernet_reset_sequencer #(
  parameter int N_CH               = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PMA_RST_CYCLES     = 64,
  parameter int GLBL_RST_CYCLES    = 256
) (
  input  logic              ref_clk,
  input  logic              rst,
  input  logic              mmcm_locked,
  input  logic [N_CH-1:0]   gt0_pll0lock_in,
  input  logic [N_CH-1:0]   gt0_pll0refclklost_in,
  input  logic [N_CH-1:0]   sw_reset,
  output logic [N_CH-1:0]   pma_reset,
  output logic [N_CH-1:0]   glbl_rst,
  output logic [N_CH-1:0]   s_axi_lite_resetn,
  output logic [N_CH-1:0]   ready,
  output logic [8*N_CH-1:0] loss_cnt
);

  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int PW = $clog2(PMA_RST_CYCLES + 1);
  localparam int GW = $clog2(GLBL_RST_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [PW-1:0] PMA_LAST    = PW'(PMA_RST_CYCLES - 1);
  localparam logic [GW-1:0] GLBL_LAST   = GW'(GLBL_RST_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    PMA_HOLD  = 2'd1,
    MAC_HOLD  = 2'd2,
    RUN       = 2'd3
  } state_e;

  logic [1:0]      mmcm_sync_q;
  logic [N_CH-1:0] pll_s1_q, pll_s2_q;
  logic [N_CH-1:0] lost_s1_q, lost_s2_q;
  logic [N_CH-1:0] good_s;

  // Lost flops reset to 1 so a channel never looks good straight out of reset.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      mmcm_sync_q <= 2'b00;
      pll_s1_q    <= {N_CH{1'b0}};
      pll_s2_q    <= {N_CH{1'b0}};
      lost_s1_q   <= {N_CH{1'b1}};
      lost_s2_q   <= {N_CH{1'b1}};
    end else begin
      mmcm_sync_q <= {mmcm_sync_q[0], mmcm_locked};
      pll_s1_q    <= gt0_pll0lock_in;
      pll_s2_q    <= pll_s1_q;
      lost_s1_q   <= gt0_pll0refclklost_in;
      lost_s2_q   <= lost_s1_q;
    end
  end

  assign good_s = {N_CH{mmcm_sync_q[1]}} & pll_s2_q & ~lost_s2_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e         state_q, state_d;
    logic [SW-1:0]  stable_q, stable_d;
    logic [PW-1:0]  pma_cnt_q, pma_cnt_d;
    logic [GW-1:0]  glbl_cnt_q, glbl_cnt_d;
    logic           pma_q, glbl_q, resetn_q, ready_q;
    logic           abort_s;

    // A held sw_reset also blocks qualification in WAIT_LOCK.
    assign abort_s = ~good_s[i] | sw_reset[i];

    // Next-state and counter logic; every abort returns to WAIT_LOCK with cleared counters.
    always_comb begin
      state_d    = state_q;
      stable_d   = {SW{1'b0}};
      pma_cnt_d  = {PW{1'b0}};
      glbl_cnt_d = {GW{1'b0}};
      case (state_q)
        WAIT_LOCK: begin
          if (abort_s) begin
            state_d = WAIT_LOCK;
          end else if (stable_q == STABLE_LAST) begin
            state_d = PMA_HOLD;
          end else begin
            stable_d = stable_q + SW'(1);
          end
        end
        PMA_HOLD: begin
          if (abort_s) begin
            state_d = WAIT_LOCK;
          end else if (pma_cnt_q == PMA_LAST) begin
            state_d = MAC_HOLD;
          end else begin
            pma_cnt_d = pma_cnt_q + PW'(1);
          end
        end
        MAC_HOLD: begin
          if (abort_s) begin
            state_d = WAIT_LOCK;
          end else if (glbl_cnt_q == GLBL_LAST) begin
            state_d = RUN;
          end else begin
            glbl_cnt_d = glbl_cnt_q + GW'(1);
          end
        end
        RUN: begin
          if (abort_s) begin
            state_d = WAIT_LOCK;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = WAIT_LOCK;
      endcase
    end

    // State, counters and outputs decoded from the next state.
    always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
        state_q    <= WAIT_LOCK;
        stable_q   <= {SW{1'b0}};
        pma_cnt_q  <= {PW{1'b0}};
        glbl_cnt_q <= {GW{1'b0}};
        pma_q      <= 1'b1;
        glbl_q     <= 1'b1;
        resetn_q   <= 1'b0;
        ready_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        stable_q   <= stable_d;
        pma_cnt_q  <= pma_cnt_d;
        glbl_cnt_q <= glbl_cnt_d;
        pma_q      <= (state_d == WAIT_LOCK) || (state_d == PMA_HOLD);
        glbl_q     <= (state_d != RUN);
        resetn_q   <= (state_d == RUN);
        ready_q    <= (state_d == RUN);
      end
    end

    assign pma_reset[i]         = pma_q;
    assign glbl_rst[i]          = glbl_q;
    assign s_axi_lite_resetn[i] = resetn_q;
    assign ready[i]             = ready_q;

`ifdef RESET_SEQ_LOSS_CNT_EN
    logic [7:0] loss_q;
    logic       loss_inc_s;

    // Only an exit from RUN caused by a bad clock status counts as a loss.
    assign loss_inc_s = (state_q == RUN) & ~good_s[i];

    // Saturating loss counter, cleared only by rst.
    always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
        loss_q <= 8'd0;
      end else if (loss_inc_s && (loss_q != 8'hFF)) begin
        loss_q <= loss_q + 8'd1;
      end else begin
        loss_q <= loss_q;
      end
    end

    assign loss_cnt[8*i +: 8] = loss_q;
`else
    assign loss_cnt[8*i +: 8] = 8'd0;
`endif
  end

endmodule

// File: tb/tb_axi_ethernet_reset_sequencer.sv
// Self-checking bench: a consecutive-good-sample age model predicts every output.
module tb_axi_ethernet_reset_sequencer;

  localparam int N_CH    = 2;
  localparam int LSC     = 4;
  localparam int PRC     = 3;
  localparam int GRC     = 5;
  localparam int PMA_END = LSC + PRC;
  localparam int RUN_AGE = LSC + PRC + GRC;
`ifdef RESET_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic        ref_clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmcm_locked = 1'b0;
  logic [1:0]  gt0_pll0lock_in = 2'b00;
  logic [1:0]  gt0_pll0refclklost_in = 2'b11;
  logic [1:0]  sw_reset = 2'b00;
  logic [1:0]  pma_reset, glbl_rst, s_axi_lite_resetn, ready;
  logic [15:0] loss_cnt;

  int errors = 0;
  int checks = 0;

  // Model: a channel's age is the run of consecutive edges that saw good and no sw_reset.
  int         age [2];
  int         loss [2];
  logic       h1_m, h2_m;
  logic [1:0] h1_l, h2_l, h1_x, h2_x;
  logic [1:0] exp_pma, exp_glbl, exp_ready;
  logic [15:0] exp_loss;

  axi_ethernet_reset_sequencer #(
    .N_CH(N_CH), .LOCK_STABLE_CYCLES(LSC), .PMA_RST_CYCLES(PRC), .GLBL_RST_CYCLES(GRC)
  ) dut (
    .ref_clk(ref_clk), .rst(rst), .mmcm_locked(mmcm_locked),
    .gt0_pll0lock_in(gt0_pll0lock_in), .gt0_pll0refclklost_in(gt0_pll0refclklost_in),
    .sw_reset(sw_reset), .pma_reset(pma_reset), .glbl_rst(glbl_rst),
    .s_axi_lite_resetn(s_axi_lite_resetn), .ready(ready), .loss_cnt(loss_cnt)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic refresh();
    for (int c = 0; c < 2; c++) begin
      exp_pma[c]   = (age[c] < PMA_END);
      exp_glbl[c]  = (age[c] < RUN_AGE);
      exp_ready[c] = (age[c] >= RUN_AGE);
      exp_loss[8*c +: 8] = LOSS_EN ? 8'(loss[c]) : 8'd0;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      age[c]  = 0;
      loss[c] = 0;
    end
    h1_m = 1'b0; h2_m = 1'b0;
    h1_l = 2'b00; h2_l = 2'b00;
    h1_x = 2'b11; h2_x = 2'b11;
    refresh();
  endtask

  // One clock edge: the FSM sees inputs from two edges ago, sw_reset from this edge.
  task automatic step();
    @(posedge ref_clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < 2; c++) begin
        logic g;
        g = h2_m & h2_l[c] & ~h2_x[c];
        if (g && !sw_reset[c]) begin
          if (age[c] < RUN_AGE) age[c]++;
        end else begin
          if (age[c] >= RUN_AGE && !g && loss[c] < 255) loss[c]++;
          age[c] = 0;
        end
      end
      h2_m = h1_m; h2_l = h1_l; h2_x = h1_x;
      h1_m = mmcm_locked; h1_l = gt0_pll0lock_in; h1_x = gt0_pll0refclklost_in;
      refresh();
    end
    #1;
  endtask

  // Good inputs, then rst released just after an edge; the next edge is edge 0.
  task automatic release_good();
    rst = 1'b1;
    model_reset();
    mmcm_locked = 1'b1; gt0_pll0lock_in = 2'b11; gt0_pll0refclklost_in = 2'b00; sw_reset = 2'b00;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) step();
    checks++; if (pma_reset !== 2'b11) begin errors++; $display("FAIL reset_pma: got %b expected 11", pma_reset); end
    checks++; if (glbl_rst !== 2'b11) begin errors++; $display("FAIL reset_glbl: got %b expected 11", glbl_rst); end
    checks++; if (s_axi_lite_resetn !== 2'b00) begin errors++; $display("FAIL reset_resetn: got %b expected 00", s_axi_lite_resetn); end
    checks++; if (ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", ready); end
    checks++; if (loss_cnt !== 16'd0) begin errors++; $display("FAIL reset_loss: got %h expected 0000", loss_cnt); end
  endtask

  task automatic test_power_up();
    release_good();
    for (int e = 0; e < 16; e++) begin
      step();
      checks++; if (pma_reset !== ((e >= 8) ? 2'b00 : 2'b11)) begin errors++; $display("FAIL power_up_pma e%0d: got %b", e, pma_reset); end
      checks++; if (glbl_rst !== ((e >= 13) ? 2'b00 : 2'b11)) begin errors++; $display("FAIL power_up_glbl e%0d: got %b", e, glbl_rst); end
      checks++; if (ready !== ((e >= 13) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL power_up_ready e%0d: got %b", e, ready); end
      checks++; if (s_axi_lite_resetn !== ~glbl_rst) begin errors++; $display("FAIL power_up_resetn e%0d: got %b glbl %b", e, s_axi_lite_resetn, glbl_rst); end
    end
  endtask

  task automatic test_lock_glitch();
    release_good();
    for (int e = 0; e < 19; e++) begin
      step();
      if (e == 2) gt0_pll0lock_in[0] = 1'b0;
      if (e == 3) gt0_pll0lock_in[0] = 1'b1;
      checks++; if ({pma_reset, ready} !== {exp_pma, exp_ready}) begin errors++; $display("FAIL glitch_model e%0d: got pma %b rdy %b expected %b %b", e, pma_reset, ready, exp_pma, exp_ready); end
      if (e == 13) begin
        checks++; if (ready !== 2'b10) begin errors++; $display("FAIL glitch_ch1_first: got %b expected 10", ready); end
      end
      if (e == 17) begin
        checks++; if (ready !== 2'b11) begin errors++; $display("FAIL glitch_ch0_late: got %b expected 11", ready); end
      end
    end
  endtask

  task automatic test_clock_loss();
    gt0_pll0refclklost_in[1] = 1'b1;
    step(); step();
    checks++; if (ready !== 2'b11) begin errors++; $display("FAIL loss_early: got %b expected 11", ready); end
    step();
    checks++; if ({pma_reset, glbl_rst, ready} !== 6'b10_10_01) begin errors++; $display("FAIL loss_outputs: got pma %b glbl %b rdy %b", pma_reset, glbl_rst, ready); end
    checks++; if (loss_cnt !== (LOSS_EN ? 16'h0100 : 16'h0000)) begin errors++; $display("FAIL loss_count: got %h", loss_cnt); end
    gt0_pll0refclklost_in[1] = 1'b0;
    repeat (RUN_AGE + 2) step();
    checks++; if (ready !== 2'b11) begin errors++; $display("FAIL loss_recover: got %b expected 11", ready); end
  endtask

  task automatic test_shared_loss();
    mmcm_locked = 1'b0;
    step(); step();
    checks++; if (ready !== 2'b11) begin errors++; $display("FAIL shared_early: got %b expected 11", ready); end
    step();
    checks++; if ({pma_reset, ready} !== 4'b11_00) begin errors++; $display("FAIL shared_outputs: got pma %b rdy %b", pma_reset, ready); end
    checks++; if (loss_cnt !== exp_loss) begin errors++; $display("FAIL shared_count: got %h expected %h", loss_cnt, exp_loss); end
    mmcm_locked = 1'b1;
    repeat (RUN_AGE + 2) step();
    checks++; if (ready !== 2'b11) begin errors++; $display("FAIL shared_recover: got %b expected 11", ready); end
  endtask

  task automatic test_sw_reset();
    sw_reset[0] = 1'b1;
    step();
    sw_reset[0] = 1'b0;
    checks++; if ({glbl_rst, ready} !== 4'b01_10) begin errors++; $display("FAIL sw_assert: got glbl %b rdy %b", glbl_rst, ready); end
    checks++; if (loss_cnt !== exp_loss) begin errors++; $display("FAIL sw_no_count: got %h expected %h", loss_cnt, exp_loss); end
    for (int j = 1; j <= 12; j++) begin
      step();
      checks++; if (ready[0] !== (j >= 12)) begin errors++; $display("FAIL sw_rerelease j%0d: got %b", j, ready[0]); end
    end
  endtask

  task automatic test_mid_reset();
    release_good();
    repeat (11) step();
    checks++; if ({pma_reset, glbl_rst} !== 4'b00_11) begin errors++; $display("FAIL mid_mac_hold: got pma %b glbl %b", pma_reset, glbl_rst); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if ({pma_reset, glbl_rst, s_axi_lite_resetn, ready} !== 8'b11_11_00_00) begin errors++; $display("FAIL mid_async: got pma %b glbl %b rn %b rdy %b", pma_reset, glbl_rst, s_axi_lite_resetn, ready); end
    step(); step();
    checks++; if ({pma_reset, ready} !== 4'b11_00) begin errors++; $display("FAIL mid_held: got pma %b rdy %b", pma_reset, ready); end
  endtask

  task automatic test_saturation();
    release_good();
    repeat (RUN_AGE + 3) step();
    for (int n = 0; n < 300; n++) begin
      gt0_pll0refclklost_in[0] = 1'b1;
      repeat (3) step();
      gt0_pll0refclklost_in[0] = 1'b0;
      repeat (RUN_AGE + 2) step();
      checks++; if (loss_cnt !== exp_loss) begin errors++; $display("FAIL sat_iter%0d: got %h expected %h", n, loss_cnt, exp_loss); end
    end
    checks++; if (loss_cnt[7:0] !== (LOSS_EN ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_final: got %0d", loss_cnt[7:0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      mmcm_locked = ($urandom_range(0, 99) != 0);
      for (int c = 0; c < 2; c++) begin
        gt0_pll0lock_in[c]       = ($urandom_range(0, 59) != 0);
        gt0_pll0refclklost_in[c] = ($urandom_range(0, 59) == 0);
        sw_reset[c]              = ($urandom_range(0, 79) == 0);
      end
      step();
      checks++; if ({pma_reset, glbl_rst, s_axi_lite_resetn, ready} !== {exp_pma, exp_glbl, ~exp_glbl, exp_ready}) begin
        errors++; $display("FAIL random_out n%0d: got %b %b %b %b expected %b %b %b %b", n, pma_reset, glbl_rst, s_axi_lite_resetn, ready, exp_pma, exp_glbl, ~exp_glbl, exp_ready);
      end
      checks++; if (loss_cnt !== exp_loss) begin errors++; $display("FAIL random_loss n%0d: got %h expected %h", n, loss_cnt, exp_loss); end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_clock_loss();
    test_shared_loss();
    test_sw_reset();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
